// File: rtl/fb_ctrl_pkg.sv
// Shared types for the framebuffer swap controller.
//   fb_state_e : controller state encoding
//   fb_mask_t  : per-buffer target mask, bit i selects buffer instance i
package fb_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_INIT       = 3'd0,
    ST_CLR_PULSE  = 3'd1,
    ST_CLR_GUARD  = 3'd2,
    ST_CLR_WAIT   = 3'd3,
    ST_RENDER     = 3'd4,
    ST_WAIT_VSYNC = 3'd5,
    ST_SWAP       = 3'd6
  } fb_state_e;

  typedef logic [1:0] fb_mask_t;

  localparam fb_mask_t MASK_BOTH = 2'b11;
  localparam fb_mask_t MASK_NONE = 2'b00;

endpackage

// File: rtl/framebuffer_swap_ctrl.sv
// Double-buffer swap controller.
// Clears both buffers after reset, lets the renderer draw into the back
// buffer, and swaps front/back on the first vsync after frame_done.
// Optionally clears the new back buffer after each swap.
// Ports:
//   clk, rstn               clock, async active-low reset
//   frame_done, vsync       renderer / display pulses (synchronous to clk)
//   buf0_ready, buf1_ready  buffer instances report clear finished
//   clear_0, clear_1        one-cycle clear requests
//   front_sel, back_sel     display / renderer buffer index (back = ~front)
//   render_ready            renderer may write the back buffer
//   swapped                 pulse in the cycle front_sel changes
//   frame_count             completed swaps, wraps
//   missed_vsync            vsyncs seen while rendering, saturates
module framebuffer_swap_ctrl
  import fb_ctrl_pkg::*;
#(
  parameter int CLEAR_ON_SWAP = 1,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   frame_done,
  input  logic                   vsync,
  input  logic                   buf0_ready,
  input  logic                   buf1_ready,
  output logic                   clear_0,
  output logic                   clear_1,
  output logic                   front_sel,
  output logic                   back_sel,
  output logic                   render_ready,
  output logic                   swapped,
  output logic [COUNT_WIDTH-1:0] frame_count,
  output logic [COUNT_WIDTH-1:0] missed_vsync
);

  fb_state_e state, state_nx;
  fb_mask_t  mask, mask_nx;
  fb_mask_t  ready;

  assign ready = {buf1_ready, buf0_ready};

  always_comb begin
    state_nx = state;
    mask_nx  = mask;
    unique case (state)
      ST_INIT: begin
        mask_nx  = MASK_BOTH;
        state_nx = ST_CLR_PULSE;
      end
      ST_CLR_PULSE: state_nx = ST_CLR_GUARD;
      // A buffer's ready is still high the cycle after the clear pulse,
      // so it cannot be trusted here.
      ST_CLR_GUARD: state_nx = ST_CLR_WAIT;
      ST_CLR_WAIT:  if ((ready & mask) == mask) state_nx = ST_RENDER;
      ST_RENDER: begin
        if (frame_done) state_nx = vsync ? ST_SWAP : ST_WAIT_VSYNC;
      end
      ST_WAIT_VSYNC: if (vsync) state_nx = ST_SWAP;
      ST_SWAP: begin
        if (CLEAR_ON_SWAP != 0) begin
          // front_sel already toggled, so back_sel names the old front,
          // which is now the buffer the renderer will draw into.
          mask_nx  = back_sel ? 2'b10 : 2'b01;
          state_nx = ST_CLR_PULSE;
        end else begin
          state_nx = ST_RENDER;
        end
      end
      default: state_nx = ST_INIT;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet
  // line up with the state they describe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= ST_INIT;
      mask         <= MASK_NONE;
      front_sel    <= 1'b0;
      back_sel     <= 1'b1;
      clear_0      <= 1'b0;
      clear_1      <= 1'b0;
      render_ready <= 1'b0;
      swapped      <= 1'b0;
      frame_count  <= '0;
      missed_vsync <= '0;
    end else begin
      state        <= state_nx;
      mask         <= mask_nx;
      clear_0      <= (state_nx == ST_CLR_PULSE) && mask_nx[0];
      clear_1      <= (state_nx == ST_CLR_PULSE) && mask_nx[1];
      render_ready <= (state_nx == ST_RENDER);
      swapped      <= (state_nx == ST_SWAP);
      if (state_nx == ST_SWAP) begin
        front_sel   <= back_sel;
        back_sel    <= front_sel;
        frame_count <= frame_count + COUNT_WIDTH'(1);
      end
      if (state == ST_RENDER && vsync && !frame_done && missed_vsync != '1)
        missed_vsync <= missed_vsync + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_framebuffer_swap_ctrl.sv
// Bench: two controllers (A: clear on swap, 16-bit counts; B: no clear on
// swap, 2-bit counts) sharing stimulus, each with two depth-16 buffers.
// A timestamp-based reference model predicts every output each cycle.
module tb_framebuffer_swap_ctrl;

  localparam int M_INIT = 0, M_CLEAR = 1, M_RENDER = 2, M_WAIT = 3, M_SWAP = 4;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic frame_done = 1'b0;
  logic vsync = 1'b0;
  logic chk_en = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  logic [1:0]  clr_a, clr_b;
  logic [1:0]  clr [2];
  logic        o_front [2], o_back [2], o_rr [2], o_sw [2];
  logic [15:0] fc_a, mv_a;
  logic [1:0]  fc_b, mv_b;
  logic [15:0] o_fc [2], o_mv [2];
  logic        rdy  [2][2] = '{'{1'b0, 1'b0}, '{1'b0, 1'b0}};
  logic        busy [2][2] = '{'{1'b0, 1'b0}, '{1'b0, 1'b0}};
  logic [3:0]  addr [2][2] = '{'{4'd0, 4'd0}, '{4'd0, 4'd0}};

  assign clr[0]  = clr_a;
  assign clr[1]  = clr_b;
  assign o_fc[0] = fc_a;
  assign o_mv[0] = mv_a;
  assign o_fc[1] = {14'd0, fc_b};
  assign o_mv[1] = {14'd0, mv_b};

  framebuffer_swap_ctrl #(.CLEAR_ON_SWAP(1), .COUNT_WIDTH(16)) u_a (
    .clk(clk), .rstn(rstn), .frame_done(frame_done), .vsync(vsync),
    .buf0_ready(rdy[0][0]), .buf1_ready(rdy[0][1]),
    .clear_0(clr_a[0]), .clear_1(clr_a[1]),
    .front_sel(o_front[0]), .back_sel(o_back[0]),
    .render_ready(o_rr[0]), .swapped(o_sw[0]),
    .frame_count(fc_a), .missed_vsync(mv_a)
  );

  framebuffer_swap_ctrl #(.CLEAR_ON_SWAP(0), .COUNT_WIDTH(2)) u_b (
    .clk(clk), .rstn(rstn), .frame_done(frame_done), .vsync(vsync),
    .buf0_ready(rdy[1][0]), .buf1_ready(rdy[1][1]),
    .clear_0(clr_b[0]), .clear_1(clr_b[1]),
    .front_sel(o_front[1]), .back_sel(o_back[1]),
    .render_ready(o_rr[1]), .swapped(o_sw[1]),
    .frame_count(fc_b), .missed_vsync(mv_b)
  );

  // Buffer models (no reset): clear writes word 0 at the pulse edge and
  // one word per cycle after; ready stays stale-high one cycle, drops,
  // and rises 16 cycles after the pulse. Clears while busy are ignored.
  always @(posedge clk)
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 2; i++)
        if (busy[k][i]) begin
          addr[k][i] <= addr[k][i] + 4'd1;
          if (addr[k][i] == 4'd15) begin
            busy[k][i] <= 1'b0;
            rdy[k][i]  <= 1'b1;
          end else begin
            rdy[k][i]  <= 1'b0;
          end
        end else if (clr[k][i]) begin
          busy[k][i] <= 1'b1;
          addr[k][i] <= 4'd1;
        end

  // ---------------- reference model ----------------
  int         t = 0;
  int         mode [2];
  int         rr_at [2];
  int         lastc [2][2] = '{'{-100, -100}, '{-100, -100}};
  logic       e_front [2], e_rr [2], e_sw [2];
  logic [1:0] e_clr [2];
  int         e_fc [2], e_mv [2];

  always @(posedge clk) t <= t + 1;

  function automatic int cmax(input int k);
    return (k == 0) ? 65535 : 3;
  endfunction

  task automatic m_reset(input int k);
    mode[k] = M_INIT; e_front[k] = 1'b0; e_rr[k] = 1'b0; e_sw[k] = 1'b0;
    e_clr[k] = 2'b00; e_fc[k] = 0; e_mv[k] = 0;
  endtask

  // Clear pulse at cycle 'now': render starts the cycle after the later of
  // (now+2) and the moment every targeted buffer is ready.
  task automatic m_clear(input int k, input logic [1:0] m, input int now);
    int latest;
    latest = now + 2;
    e_clr[k] = m;
    mode[k] = M_CLEAR;
    for (int i = 0; i < 2; i++)
      if (m[i]) begin
        if (!(now > lastc[k][i] && now <= lastc[k][i] + 15)) lastc[k][i] = now;
        if (lastc[k][i] + 16 > latest) latest = lastc[k][i] + 16;
      end
    rr_at[k] = latest + 1;
  endtask

  task automatic m_swap(input int k);
    e_sw[k] = 1'b1; e_front[k] = !e_front[k];
    e_fc[k] = (e_fc[k] + 1) % (cmax(k) + 1);
    e_rr[k] = 1'b0; mode[k] = M_SWAP;
  endtask

  task automatic m_step(input int k, input logic fd, input logic vs, input int now);
    e_sw[k] = 1'b0; e_clr[k] = 2'b00;
    case (mode[k])
      M_INIT:  m_clear(k, 2'b11, now);
      M_CLEAR: if (now >= rr_at[k]) begin mode[k] = M_RENDER; e_rr[k] = 1'b1; end
      M_RENDER: begin
        if (fd && vs) m_swap(k);
        else if (fd) begin mode[k] = M_WAIT; e_rr[k] = 1'b0; end
        else if (vs && e_mv[k] < cmax(k)) e_mv[k]++;
      end
      M_WAIT: if (vs) m_swap(k);
      M_SWAP: begin
        if (k == 0) m_clear(k, e_front[k] ? 2'b01 : 2'b10, now);
        else begin mode[k] = M_RENDER; e_rr[k] = 1'b1; end
      end
      default: ;
    endcase
  endtask

  always @(posedge clk or negedge rstn)
    if (!rstn) begin
      m_reset(0); m_reset(1);
    end else begin
      m_step(0, frame_done, vsync, t + 1);
      m_step(1, frame_done, vsync, t + 1);
    end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s got=%0h exp=%0h t=%0d", tag, got, exp, t);
    end
  endtask

  always @(negedge clk)
    if (chk_en)
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("%0d.front", k), 32'(o_front[k]), 32'(e_front[k]));
        chk($sformatf("%0d.back", k),  32'(o_back[k]),  32'(!e_front[k]));
        chk($sformatf("%0d.rr", k),    32'(o_rr[k]),    32'(e_rr[k]));
        chk($sformatf("%0d.sw", k),    32'(o_sw[k]),    32'(e_sw[k]));
        chk($sformatf("%0d.clr", k),   32'(clr[k]),     32'(e_clr[k]));
        chk($sformatf("%0d.fc", k),    32'(o_fc[k]),    e_fc[k]);
        chk($sformatf("%0d.mv", k),    32'(o_mv[k]),    e_mv[k]);
      end

  // ---------------- stimulus ----------------
  task automatic step(input logic fd, input logic vs);
    frame_done = fd;
    vsync = vs;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rr();
    for (int i = 0; i < 80 && !(o_rr[0] && o_rr[1]); i++) step(1'b0, 1'b0);
    chk("wait_rr", 32'(o_rr[0] && o_rr[1]), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cnt;
    logic fs;
    #1 rstn = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); @(posedge clk); #1 rstn = 1'b1;   // release cycle = cycle 1

    // reset release: clears at cycle 2, render_ready at cycle 19
    step(1'b0, 1'b0);
    chk("init_clr_a", 32'(clr_a), 32'd3);
    chk("init_clr_b", 32'(clr_b), 32'd3);
    repeat (16) step(1'b0, 1'b0);
    chk("rr_c18", 32'(o_rr[0]), 32'd0);
    step(1'b0, 1'b0);
    chk("rr_c19", 32'(o_rr[0]), 32'd1);
    chk("front_c19", 32'(o_front[0]), 32'd0);

    // frame_done, vsync 5 cycles later
    step(1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("swap_sw", 32'(o_sw[0]), 32'd1);
    chk("swap_front", 32'(o_front[0]), 32'd1);
    chk("swap_fc", 32'(fc_a), 32'd1);
    cnt = 1;
    step(1'b0, 1'b0);
    chk("swap_clr_a", 32'(clr_a), 32'd1);
    chk("swap_clr_b", 32'(clr_b), 32'd0);
    while (!o_rr[0] && cnt < 60) begin cnt++; step(1'b0, 1'b0); end
    chk("rr_low_cycles", cnt, 32'd18);

    // frame_done and vsync together
    step(1'b1, 1'b1);
    chk("same_sw_a", 32'(o_sw[0]), 32'd1);
    chk("same_sw_b", 32'(o_sw[1]), 32'd1);
    chk("same_mv", 32'(mv_a), 32'd0);
    wait_rr();

    // three vsyncs with no frame_done
    fs = o_front[0];
    repeat (3) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("miss_a", 32'(mv_a), 32'd3);
    chk("miss_b_sat", 32'(mv_b), 32'd3);
    chk("miss_front", 32'(o_front[0]), 32'(fs));

    // reset in the middle of a clear
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    repeat (8) step(1'b0, 1'b0);
    rstn = 1'b0;
    #1;
    chk("rst_rr", 32'(o_rr[0]), 32'd0);
    chk("rst_fc", 32'(fc_a), 32'd0);
    chk("rst_back", 32'(o_back[0]), 32'd1);
    chk("rst_mv", 32'(mv_a), 32'd0);
    @(posedge clk); @(posedge clk); #1 rstn = 1'b1;
    wait_rr();
    chk("rst_bufs_ready", 32'(rdy[0][0] && rdy[0][1]), 32'd1);

    // five swaps: B wraps its 2-bit counter
    repeat (5) begin step(1'b1, 1'b1); wait_rr(); end
    chk("wrap_fc_b", 32'(fc_b), 32'd1);
    chk("wrap_front_b", 32'(o_front[1]), 32'd1);
    chk("five_fc_a", 32'(fc_a), 32'd5);

    // random traffic with occasional resets
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        rstn = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1 rstn = 1'b1;
      end
      step($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
